// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flop reused LSB-first over WIDTH cycles.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port for two's-complement subtraction (a - b).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sa, sb, ss;
  logic               c;
  logic [CNT_W-1:0]   cnt;

  logic               s_bit;
  logic               c_nxt;
  logic               last_bit;
  logic [WIDTH-1:0]   b_load;
  logic               c_init;

  // Subtraction is a + ~b + 1: invert B at load time and seed the carry with 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_init = sub;
`else
  assign b_load = b;
  assign c_init = 1'b0;
`endif

  // The single full-adder cell.
  assign s_bit    = sa[0] ^ sb[0] ^ c;
  assign c_nxt    = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: assign a default before the case so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: operand/partial-sum shifters, carry, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      ss   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b_load;
            ss  <= '0;
            c   <= c_init;
            cnt <= '0;
          end
        end
        RUN: begin
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          ss  <= {s_bit, ss[WIDTH-1:1]};
          c   <= c_nxt;
          cnt <= cnt + 1'b1;
          // Results publish only on the final bit so partial sums are never visible.
          if (last_bit) begin
            sum  <= {s_bit, ss[WIDTH-1:1]};
            cout <= c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a driver predicts each accepted operation, a monitor checks outputs.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         sub_i;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_k = -1000;
  int   next_free = 0;
  exp_t exp_q[$];
  logic [W-1:0] hold_sum = '0;
  logic         hold_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_i),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: plain integer arithmetic on the captured operands.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic sv, input int due);
    exp_t        r;
    int unsigned ai, bi, t;
    ai = av;
    bi = bv;
    if (sv) begin
      r.sum  = W'(ai - bi);
      r.cout = (ai >= bi);
    end else begin
      t      = ai + bi;
      r.sum  = W'(t);
      r.cout = 1'((t >> W) & 1);
    end
    r.due = due;
    return r;
  endfunction

  // One input cycle: drive at the falling edge and predict whether the next rising edge accepts.
  task automatic step(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    int k;
    @(negedge clk);
    start = s;
    a     = av;
    b     = bv;
    sub_i = sv;
    if (s && rst_n && (cyc + 1 >= next_free)) begin
      k         = cyc + 1;
      last_k    = k;
      next_free = k + W + 2;
`ifdef SERIAL_ADDER_SUB_EN
      exp_q.push_back(model(av, bv, sv, k + W));
`else
      exp_q.push_back(model(av, bv, 1'b0, k + W));
`endif
    end
  endtask

  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    while (cyc + 1 < next_free) step(1'b0, W'($urandom), W'($urandom), 1'b0);
    step(1'b1, av, bv, sv);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n     = 1'b0;
    start     = 1'b0;
    exp_q.delete();
    last_k    = -1000;
    next_free = 0;
    hold_sum  = '0;
    hold_cout = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: samples 1 ns after each rising edge.
  always @(posedge clk) begin
    int   e;
    exp_t it;
    cyc++;
    #1;
    e = cyc;
    check("busy", busy, 32'(rst_n && e >= last_k && e <= last_k + W - 1));
    check("done", done, 32'(rst_n && e == last_k + W));
    if (done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        it = exp_q.pop_front();
        check("sum", sum, it.sum);
        check("cout", cout, it.cout);
        check("done_edge", e, it.due);
        hold_sum  = it.sum;
        hold_cout = it.cout;
      end
    end
    check("sum_hold", sum, hold_sum);
    check("cout_hold", cout, hold_cout);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h33;
    sub_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;

    op(8'h05, 8'h03, 1'b0);
    op(8'hFF, 8'h01, 1'b0);
    op(8'hAA, 8'h55, 1'b0);
    op(8'h00, 8'h00, 1'b0);
    op(8'hFF, 8'hFF, 1'b0);

    // Start held high through a whole operation while operands wander.
    op(8'h10, 8'h20, 1'b0);
    for (int i = 0; i < W + 4; i++) step(1'b1, W'($urandom), W'($urandom), 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0);

    // Reset during the 4th RUN cycle, then a fresh operation.
    op(8'h21, 8'h42, 1'b0);
    repeat (3) step(1'b0, 8'h00, 8'h00, 1'b0);
    do_reset(2);
    op(8'h21, 8'h42, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    op(8'h05, 8'h07, 1'b1);
    op(8'h07, 8'h05, 1'b1);
    op(8'h80, 8'h80, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, W'($urandom), W'($urandom), 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
      op(W'($urandom), W'($urandom), 1'($urandom));
`else
      op(W'($urandom), W'($urandom), 1'b0);
`endif
    end

    repeat (W + 4) step(1'b0, 8'h00, 8'h00, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
